// File: rtl/mb_event_pkg.sv
// Shared definitions for the Modbus event queue: event codes, default code width, clog2 helper.
package mb_event_pkg;

  localparam int EV_W_DEF = 3;

  typedef enum logic [EV_W_DEF-1:0] {
    EV_READY          = 3'd0,
    EV_FRAME_RECEIVED = 3'd1,
    EV_EXECUTE        = 3'd2,
    EV_FRAME_SENT     = 3'd3
  } mb_event_e;

  function automatic int mb_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mb_event_arb.sv
// Fixed-priority arbiter: one-hot grant to the lowest-index active request. Purely combinational.
module mb_event_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  // Isolate the lowest set bit.
  assign grant_o = req_i & ~(req_i - N'(1));

endmodule

// File: rtl/mb_event_queue.sv
// Multi-source event FIFO with show-ahead head and sticky underflow flag.
// Optional macro MB_EVENT_COALESCE_EN drops a post that repeats the newest queued code.
module mb_event_queue
  import mb_event_pkg::*;
#(
  parameter int EV_W    = EV_W_DEF,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 2,
  localparam int SRC_W  = (NUM_SRC > 1) ? mb_clog2(NUM_SRC) : 1,
  localparam int CNT_W  = mb_clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      post_valid,
  input  logic [NUM_SRC*EV_W-1:0] post_event,
  output logic [NUM_SRC-1:0]      post_ready,
  input  logic                    get_req,
  output logic                    ev_valid,
  output logic [EV_W-1:0]         ev_code,
  output logic [SRC_W-1:0]        ev_src,
  output logic [CNT_W-1:0]        count,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int PTR_W = mb_clog2(DEPTH);
  localparam int ENT_W = EV_W + SRC_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   win_idx;
  logic [EV_W-1:0]    win_code;
  logic               pop, room, accept, do_write;

  mb_event_arb #(.N(NUM_SRC)) u_arb (
    .req_i   (post_valid),
    .grant_o (grant)
  );

  always_comb begin
    win_idx  = '0;
    win_code = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_idx  = SRC_W'(i);
        win_code = post_event[i*EV_W +: EV_W];
      end
    end
  end

  assign ev_valid   = (count_q != '0);
  assign pop        = get_req & ev_valid;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign room       = (count_q < CNT_W'(DEPTH)) | pop;
  assign post_ready = grant & {NUM_SRC{room}};
  assign accept     = (|post_valid) & room;

`ifdef MB_EVENT_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;
  logic             last_popped, last_match;
  assign last_ptr    = wr_ptr_q - PTR_W'(1);
  assign last_popped = pop & (count_q == CNT_W'(1));
  assign last_match  = (mem_q[last_ptr][ENT_W-1:SRC_W] == win_code);
  assign do_write    = accept & ~(ev_valid & ~last_popped & last_match);
`else
  assign do_write    = accept;
`endif

  always_comb begin
    rd_ptr_d    = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d    = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d     = count_q;
    if (do_write && !pop)      count_d = count_q + CNT_W'(1);
    else if (!do_write && pop) count_d = count_q - CNT_W'(1);
    // Set takes priority over a simultaneous clear.
    underflow_d = (get_req & ~ev_valid) | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= {win_code, win_idx};
  end

  assign ev_code   = ev_valid ? mem_q[rd_ptr_q][ENT_W-1:SRC_W] : EV_W'(EV_READY);
  assign ev_src    = ev_valid ? mem_q[rd_ptr_q][SRC_W-1:0] : '0;
  assign count     = count_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_mb_event_queue.sv
// Directed bench for mb_event_queue with a scoreboard queue of expected {code,src} entries.
module tb_mb_event_queue;
  import mb_event_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] post_valid;
  logic [5:0] post_event;
  logic [1:0] post_ready;
  logic       get_req;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [0:0] ev_src;
  logic [2:0] count;
  logic       underflow;
  logic       err_clr;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] sb [$];

  mb_event_queue #(.EV_W(3), .DEPTH(4), .NUM_SRC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .post_valid (post_valid),
    .post_event (post_event),
    .post_ready (post_ready),
    .get_req    (get_req),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_src     (ev_src),
    .count      (count),
    .underflow  (underflow),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input logic [2:0] code, input logic src);
`ifdef MB_EVENT_COALESCE_EN
    if (sb.size() > 0 && sb[$][3:1] == code) return;
`endif
    sb.push_back({code, src});
  endfunction

  task automatic post(input int src, input logic [2:0] code);
    post_valid[src] = 1'b1;
    post_event[src*3 +: 3] = code;
    #1;
    for (int n = 0; n < 20 && !post_ready[src]; n++) step();
    if (!post_ready[src]) begin
      tests_run++;
      tests_failed++;
      $error("FAIL post_timeout src=%0d observed=0 expected=1", src);
    end else begin
      model_push(code, src[0]);
    end
    step();
    post_valid[src] = 1'b0;
  endtask

  // Compare the show-ahead head with the scoreboard front without popping.
  task automatic check_head(input string tag);
    logic [3:0] e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s scoreboard_empty observed=%0h expected=entry", tag, ev_code);
    end else begin
      e = sb[0];
      chk({tag, "_valid"}, ev_valid, 1);
      chk({tag, "_code"}, ev_code, e[3:1]);
      chk({tag, "_src"}, ev_src, e[0]);
    end
  endtask

  task automatic pop(input string tag);
    check_head(tag);
    if (sb.size() > 0) void'(sb.pop_front());
    get_req = 1'b1;
    step();
    get_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; post_valid = '0; post_event = '0; get_req = 1'b0; err_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;

    // 1: reset state
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_code", ev_code, EV_READY);
    chk("rst_ev_src", ev_src, 0);
    chk("rst_count", count, 0);
    chk("rst_post_ready", post_ready, 0);
    chk("rst_underflow", underflow, 0);

    // 2: sequential posts from two sources
    post(0, EV_FRAME_RECEIVED);
    chk("t2_count1", count, 1);
    check_head("t2_head_a");
    post(1, EV_FRAME_SENT);
    chk("t2_count2", count, 2);
    pop("t2_pop_a");
    chk("t2_count3", count, 1);
    pop("t2_pop_b");
    chk("t2_count4", count, 0);
    chk("t2_empty_code", ev_code, EV_READY);

    // 3: simultaneous posts, LSB wins first
    post_valid = 2'b11;
    post_event = {EV_FRAME_SENT, EV_EXECUTE};
    #1;
    chk("t3_ready_a", post_ready, 2'b01);
    model_push(EV_EXECUTE, 1'b0);
    step();
    post_valid[0] = 1'b0;
    #1;
    chk("t3_ready_b", post_ready, 2'b10);
    model_push(EV_FRAME_SENT, 1'b1);
    step();
    post_valid = '0;
    chk("t3_count", count, 2);
    pop("t3_pop_a");
    pop("t3_pop_b");

    // 4: fill, blocked when full, post+pop when full wraps the write pointer
    post(0, 3'd1);
    post(0, 3'd2);
    post(0, 3'd3);
    post(0, 3'd1);
    chk("t4_full_count", count, 4);
    post_valid[0] = 1'b1;
    post_event[2:0] = 3'd2;
    #1;
    chk("t4_full_ready", post_ready, 2'b00);
    get_req = 1'b1;
    #1;
    chk("t4_full_pop_ready", post_ready, 2'b01);
    check_head("t4_head_before");
    void'(sb.pop_front());
    model_push(3'd2, 1'b0);
    step();
    get_req = 1'b0;
    post_valid = '0;
    chk("t4_count_after", count, 4);
    chk("t4_head_after", ev_code, 3'd2);
    pop("t4_drain_a");
    pop("t4_drain_b");
    pop("t4_drain_c");
    pop("t4_drain_d");
    chk("t4_count_empty", count, 0);

    // 5: underflow sticky, set wins over clear, post accepted while popping empty
    get_req = 1'b1;
    step();
    get_req = 1'b0;
    chk("t5_uf_set", underflow, 1);
    chk("t5_uf_count", count, 0);
    step(); step();
    chk("t5_uf_hold", underflow, 1);
    get_req = 1'b1; err_clr = 1'b1;
    step();
    get_req = 1'b0; err_clr = 1'b0;
    chk("t5_uf_set_wins", underflow, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_uf_clear", underflow, 0);
    post_valid[1] = 1'b1;
    post_event[5:3] = EV_EXECUTE;
    get_req = 1'b1;
    #1;
    chk("t5_empty_post_ready", post_ready, 2'b10);
    model_push(EV_EXECUTE, 1'b1);
    step();
    post_valid = '0; get_req = 1'b0;
    chk("t5_empty_post_count", count, 1);
    chk("t5_empty_post_uf", underflow, 1);
    check_head("t5_head");
    err_clr = 1'b1;
    pop("t5_pop");
    err_clr = 1'b0;

    // 6: repeated code
    post(0, EV_FRAME_RECEIVED);
    post(0, EV_FRAME_RECEIVED);
    post(0, EV_EXECUTE);
`ifdef MB_EVENT_COALESCE_EN
    chk("t6_count", count, 2);
`else
    chk("t6_count", count, 3);
`endif
    while (sb.size() > 0) pop("t6_pop");
    chk("t6_empty", ev_valid, 0);

    // async reset mid-operation flushes immediately
    post(0, EV_FRAME_SENT);
    post(1, EV_EXECUTE);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", ev_valid, 0);
    chk("ar_code", ev_code, EV_READY);
    sb.delete();
    step();
    rst_n = 1'b1;
    #1;
    post(1, EV_FRAME_SENT);
    check_head("ar_repost");
    pop("ar_pop");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
